// File: rtl/sip_phaser_out_pkg.sv
// ============================================================================
// Module : sip_phaser_out_pkg
// Brief  : Shared widths, bounds and tap helpers for the output phaser.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sip_phaser_out_pkg;

  localparam int c_TAP_W      = 6;
  localparam int c_READ_W     = 9;
  localparam int c_HIST_DEPTH = 127;
  localparam int c_DIV_MIN    = 2;
  localparam int c_DIV_MAX    = 16;

  typedef logic [c_TAP_W-1:0] tap_t;

  function automatic tap_t tap_step(input tap_t v, input logic inc);
    return inc ? tap_t'(v + 1'b1) : tap_t'(v - 1'b1);
  endfunction

  function automatic logic tap_wraps(input tap_t v, input logic inc);
    return inc ? (&v) : (~|v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sip_phaser_out_tap_counter.sv
// ============================================================================
// Module : phaser_tap_counter
// Brief  : 6-bit wrapping up/down tap counter with load and overflow pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module phaser_tap_counter
  import sip_phaser_out_pkg::*;
#(
  parameter tap_t INIT = '0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic       i_inc,
  input  logic       i_load,
  input  tap_t       i_load_val,
  output tap_t       o_tap,
  output logic       o_ovf
);

  tap_t r_tap;
  logic r_ovf;

  // A load always beats a step and never reports a wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tap <= INIT;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (i_load) begin
        r_tap <= i_load_val;
      end else if (i_step) begin
        r_tap <= tap_step(r_tap, i_inc);
        r_ovf <= tap_wraps(r_tap, i_inc);
      end
    end
  end

  assign o_tap = r_tap;
  assign o_ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/sip_phaser_out.sv
// ============================================================================
// Module : sip_phaser_out
// Brief  : Output-side byte-lane phaser: clock divider, tap delay, OSERDES reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sip_phaser_out
  import sip_phaser_out_pkg::*;
#(
  parameter int   CLKOUT_DIV      = 4,
  parameter int   COARSE_DELAY    = 0,
  parameter int   FINE_DELAY      = 0,
  parameter int   OCLK_DELAY      = 0,
  parameter logic COARSE_BYPASS   = 1'b0,
  parameter logic EN_OSERDES_RST  = 1'b0,
  parameter logic OCLKDELAY_INV   = 1'b0,
  parameter logic SYNC_IN_DIV_RST = 1'b0
) (
  input  logic       FREQREFCLK,
  input  logic       RST_N,
  input  logic       COARSEENABLE,
  input  logic       COARSEINC,
  input  logic       FINEENABLE,
  input  logic       FINEINC,
  input  logic       COUNTERLOADEN,
  input  logic [8:0] COUNTERLOADVAL,
  input  logic       COUNTERREADEN,
  input  logic       SELFINEOCLKDELAY,
  input  logic       DIVIDERST,
  input  logic       EDGEADV,
  input  logic       SYNCIN,
  output logic       OCLK,
  output logic       OCLKDIV,
  output logic       OCLKDELAYED,
  output logic       OSERDESRST,
  output logic       COARSEOVERFLOW,
  output logic       FINEOVERFLOW,
  output logic [8:0] COUNTERREADVAL
);

  localparam logic [4:0] c_DIV = 5'(CLKOUT_DIV);
  localparam logic [4:0] c_POS = 5'(CLKOUT_DIV / 2);

  generate
    if (CLKOUT_DIV < c_DIV_MIN || CLKOUT_DIV > c_DIV_MAX) begin : g_bad_div
      $error("sip_phaser_out: CLKOUT_DIV must be in 2..16");
    end
  endgenerate

  logic [4:0]              r_div_cnt;
  logic                    r_oclkdiv;
  logic [c_HIST_DEPTH-3:0] r_hist;
  logic                    r_odly;
  logic                    r_orst;
  logic [c_READ_W-1:0]     r_readval;

  logic                    w_divrst;
  logic [4:0]              w_div_sum;
  logic [4:0]              w_div_step;
  logic                    w_oclkdiv_next;
  logic [c_HIST_DEPTH-1:0] w_hist_next;
  logic [6:0]              w_dly;
  tap_t                    w_coarse_tap;
  tap_t                    w_fine_tap;
  tap_t                    w_oclk_tap;
  tap_t                    w_sel_tap;
  tap_t                    w_coarse_eff;
  tap_t                    w_oclk_eff;
  logic                    w_oclk_ovf_unused;
  logic [2:0]              w_loadval_unused;

  assign w_loadval_unused = COUNTERLOADVAL[8:6];

  phaser_tap_counter #(.INIT(tap_t'(COARSE_DELAY))) u_coarse (
    .i_clk      (FREQREFCLK),
    .i_rst_n    (RST_N),
    .i_step     (COARSEENABLE & ~COARSE_BYPASS),
    .i_inc      (COARSEINC),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_tap      (w_coarse_tap),
    .o_ovf      (COARSEOVERFLOW)
  );

  phaser_tap_counter #(.INIT(tap_t'(FINE_DELAY))) u_fine (
    .i_clk      (FREQREFCLK),
    .i_rst_n    (RST_N),
    .i_step     (FINEENABLE),
    .i_inc      (FINEINC),
    .i_load     (COUNTERLOADEN & ~SELFINEOCLKDELAY),
    .i_load_val (COUNTERLOADVAL[5:0]),
    .o_tap      (w_fine_tap),
    .o_ovf      (FINEOVERFLOW)
  );

  phaser_tap_counter #(.INIT(tap_t'(OCLK_DELAY))) u_oclk (
    .i_clk      (FREQREFCLK),
    .i_rst_n    (RST_N),
    .i_step     (1'b0),
    .i_inc      (1'b0),
    .i_load     (COUNTERLOADEN & SELFINEOCLKDELAY),
    .i_load_val (COUNTERLOADVAL[5:0]),
    .o_tap      (w_oclk_tap),
    .o_ovf      (w_oclk_ovf_unused)
  );

  assign w_divrst       = DIVIDERST | (SYNC_IN_DIV_RST & SYNCIN);
  assign w_div_sum      = r_div_cnt + (EDGEADV ? 5'd2 : 5'd1);
  assign w_div_step     = (w_div_sum >= c_DIV) ? (w_div_sum - c_DIV) : w_div_sum;
  assign w_oclkdiv_next = ~w_divrst & (r_div_cnt < c_POS);

  // Element k is OCLKDIV k cycles back, as it will stand after this edge.
  assign w_hist_next  = {r_hist, r_oclkdiv, w_oclkdiv_next};
  assign w_coarse_eff = COARSE_BYPASS ? '0 : w_coarse_tap;
  assign w_oclk_eff   = SELFINEOCLKDELAY ? w_oclk_tap : '0;
  assign w_dly        = {1'b0, w_coarse_eff} + {1'b0, w_oclk_eff};
  assign w_sel_tap    = SELFINEOCLKDELAY ? w_oclk_tap : w_fine_tap;

  always_ff @(posedge FREQREFCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
      r_oclkdiv <= 1'b0;
      r_hist    <= '0;
      r_odly    <= OCLKDELAY_INV;
      r_orst    <= EN_OSERDES_RST;
      r_readval <= '0;
    end else begin
      r_div_cnt <= w_divrst ? 5'd0 : w_div_step;
      r_oclkdiv <= w_oclkdiv_next;
      r_hist    <= w_hist_next[c_HIST_DEPTH-2:1];
      r_odly    <= w_hist_next[w_dly] ^ OCLKDELAY_INV;
      // Held through divider reset, released once OCLKDIV is seen high.
      r_orst    <= EN_OSERDES_RST & (w_divrst | (r_orst & ~r_oclkdiv));
      if (COUNTERREADEN) begin
        r_readval <= {{(c_READ_W - c_TAP_W){1'b0}}, w_sel_tap};
      end
    end
  end

  assign OCLK           = FREQREFCLK;
  assign OCLKDIV        = r_oclkdiv;
  assign OCLKDELAYED    = r_odly;
  assign OSERDESRST     = r_orst;
  assign COUNTERREADVAL = r_readval;

endmodule

`default_nettype wire

// File: tb/tb_sip_phaser_out.sv
// ============================================================================
// Module : tb_sip_phaser_out
// Brief  : Directed bench over three phaser configurations sharing one stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sip_phaser_out;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coarse_en, coarse_inc, fine_en, fine_inc;
  logic       load_en, read_en, sel, div_rst, edge_adv, sync_in;
  logic [8:0] load_val;

  logic       a_oclk, a_div, a_dly, a_orst, a_covf, a_fovf;
  logic [8:0] a_rd;
  logic       b_oclk, b_div, b_dly, b_orst, b_covf, b_fovf;
  logic [8:0] b_rd;
  logic       c_oclk, c_div, c_dly, c_orst, c_covf, c_fovf;
  logic [8:0] c_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  sip_phaser_out #(.CLKOUT_DIV(4)) u_a (
    .FREQREFCLK(clk), .RST_N(rst_n), .COARSEENABLE(coarse_en), .COARSEINC(coarse_inc),
    .FINEENABLE(fine_en), .FINEINC(fine_inc), .COUNTERLOADEN(load_en), .COUNTERLOADVAL(load_val),
    .COUNTERREADEN(read_en), .SELFINEOCLKDELAY(sel), .DIVIDERST(div_rst), .EDGEADV(edge_adv),
    .SYNCIN(sync_in), .OCLK(a_oclk), .OCLKDIV(a_div), .OCLKDELAYED(a_dly), .OSERDESRST(a_orst),
    .COARSEOVERFLOW(a_covf), .FINEOVERFLOW(a_fovf), .COUNTERREADVAL(a_rd)
  );

  sip_phaser_out #(.CLKOUT_DIV(5), .COARSE_DELAY(3)) u_b (
    .FREQREFCLK(clk), .RST_N(rst_n), .COARSEENABLE(coarse_en), .COARSEINC(coarse_inc),
    .FINEENABLE(fine_en), .FINEINC(fine_inc), .COUNTERLOADEN(load_en), .COUNTERLOADVAL(load_val),
    .COUNTERREADEN(read_en), .SELFINEOCLKDELAY(sel), .DIVIDERST(div_rst), .EDGEADV(edge_adv),
    .SYNCIN(sync_in), .OCLK(b_oclk), .OCLKDIV(b_div), .OCLKDELAYED(b_dly), .OSERDESRST(b_orst),
    .COARSEOVERFLOW(b_covf), .FINEOVERFLOW(b_fovf), .COUNTERREADVAL(b_rd)
  );

  sip_phaser_out #(.CLKOUT_DIV(4), .COARSE_DELAY(63), .EN_OSERDES_RST(1'b1),
                   .SYNC_IN_DIV_RST(1'b1)) u_c (
    .FREQREFCLK(clk), .RST_N(rst_n), .COARSEENABLE(coarse_en), .COARSEINC(coarse_inc),
    .FINEENABLE(fine_en), .FINEINC(fine_inc), .COUNTERLOADEN(load_en), .COUNTERLOADVAL(load_val),
    .COUNTERREADEN(read_en), .SELFINEOCLKDELAY(sel), .DIVIDERST(div_rst), .EDGEADV(edge_adv),
    .SYNCIN(sync_in), .OCLK(c_oclk), .OCLKDIV(c_div), .OCLKDELAYED(c_dly), .OSERDESRST(c_orst),
    .COARSEOVERFLOW(c_covf), .FINEOVERFLOW(c_fovf), .COUNTERREADVAL(c_rd)
  );

  // Undisturbed OCLKDIV n edges after reset release; 0 before the first edge.
  function automatic logic ediv(input int n, input int d);
    if (n <= 0) return 1'b0;
    return ((n - 1) % d) < (d / 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {coarse_en, coarse_inc, fine_en, fine_inc, load_en, read_en} = '0;
    {sel, div_rst, edge_adv, sync_in} = '0;
    load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Test 1: divider pattern, zero delay, reset values
    do_reset();
    check("rst_a_div", a_div, 1'b0);
    check("rst_a_dly", a_dly, 1'b0);
    check("rst_a_rd", a_rd, 9'h000);
    check("rst_c_orst", c_orst, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t1_div", a_div, ediv(cyc, 4));
      check("t1_dly", a_dly, ediv(cyc, 4));
      check("t1_orst", a_orst, 1'b0);
    end
    check("t1_oclk", a_oclk, 1'b1);

    // Test 2: coarse 3 then two increments to 5 at D=5
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t2_dly3", b_dly, ediv(cyc - 3, 5));
    end
    coarse_en = 1'b1; coarse_inc = 1'b1;
    repeat (2) tick();
    coarse_en = 1'b0;
    while (cyc < 20) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_dly5", b_dly, ediv(cyc - 5, 5));
    end

    // Test 3: coarse wrap 63->0->63 with overflow pulses; OSERDESRST release
    do_reset();
    tick();
    check("t3_div1", c_div, 1'b1);
    check("t3_orst1", c_orst, 1'b1);
    tick();
    check("t3_orst2", c_orst, 1'b0);
    coarse_en = 1'b1; coarse_inc = 1'b1;
    tick();
    check("t3_ovf_inc", c_covf, 1'b1);
    coarse_en = 1'b0;
    tick();
    check("t3_ovf_clr", c_covf, 1'b0);
    repeat (2) tick();
    check("t3_dly0", c_dly, ediv(cyc, 4));
    tick();
    check("t3_dly0b", c_dly, ediv(cyc, 4));
    coarse_en = 1'b1; coarse_inc = 1'b0;
    tick();
    check("t3_ovf_dec", c_covf, 1'b1);
    coarse_en = 1'b0;
    tick();
    check("t3_ovf_clr2", c_covf, 1'b0);
    while (cyc < 80) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_dly63", c_dly, ediv(cyc - 63, 4));
    end

    // Test 4: OCLK tap load/read, delay +10, load beats fine step
    do_reset();
    repeat (3) tick();
    sel = 1'b1; load_en = 1'b1; load_val = 9'h00A;
    tick();
    load_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("t4_rd_oclk", a_rd, 9'h00A);
    repeat (15) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_dly10", a_dly, ediv(cyc - 10, 4));
    end
    check("t4_rd_hold", a_rd, 9'h00A);
    sel = 1'b0; load_en = 1'b1; load_val = 9'h115; fine_en = 1'b1; fine_inc = 1'b1;
    tick();
    load_en = 1'b0; fine_en = 1'b0; read_en = 1'b1;
    tick();
    check("t4_load_wins", a_rd, 9'h015);
    check("t4_no_fovf", a_fovf, 1'b0);
    fine_en = 1'b1;
    tick();
    check("t4_rd_preupd", a_rd, 9'h015);
    read_en = 1'b0;
    repeat (2) tick();
    fine_en = 1'b0; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("t4_fine_3steps", a_rd, 9'h018);
    load_en = 1'b1; load_val = 9'h03F;
    tick();
    load_en = 1'b0; fine_en = 1'b1; fine_inc = 1'b1;
    tick();
    check("t4_fovf", a_fovf, 1'b1);
    fine_en = 1'b0;
    tick();
    check("t4_fovf_clr", a_fovf, 1'b0);
    check("t4_rd_hold2", a_rd, 9'h018);
    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rd", a_rd, 9'h000);
    check("midrst_div", c_div, 1'b0);
    check("midrst_orst", c_orst, 1'b1);

    // Test 5: DIVIDERST hold, OSERDESRST release, SYNCIN divider reset
    do_reset();
    repeat (3) tick();
    div_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_div", c_div, 1'b0);
      check("t5_hold_orst", c_orst, 1'b1);
    end
    div_rst = 1'b0;
    tick();
    check("t5_rel_div", c_div, 1'b1);
    check("t5_rel_orst", c_orst, 1'b1);
    tick();
    check("t5_rel_orst2", c_orst, 1'b0);
    check("t5_rel_div2", c_div, 1'b1);
    tick();
    check("t5_rel_div3", c_div, 1'b0);
    sync_in = 1'b1;
    repeat (2) tick();
    check("t5_sync_c", c_div, 1'b0);
    check("t5_sync_orst", c_orst, 1'b1);
    check("t5_sync_a", a_div, 1'b1);
    sync_in = 1'b0;

    // Test 6: EDGEADV phase step, and divider reset beating EDGEADV
    do_reset();
    repeat (4) tick();
    edge_adv = 1'b1;
    tick();
    check("t6_adv_edge", a_div, 1'b1);
    edge_adv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_adv", a_div, ediv(cyc + 1, 4));
    end
    edge_adv = 1'b1; div_rst = 1'b1;
    tick();
    check("t6_rst_wins", a_div, 1'b0);
    edge_adv = 1'b0; div_rst = 1'b0;
    tick();
    check("t6_after1", a_div, 1'b1);
    tick();
    check("t6_after2", a_div, 1'b1);
    tick();
    check("t6_after3", a_div, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sip_phaser_out.md
# sip_phaser_out

Cycle-level, synthesizable model of the output-side phaser of a memory PHY byte lane. It derives a divided clock (OCLKDIV) from the reference clock, applies a run-time adjustable coarse and OCLK tap delay to produce OCLKDELAYED, and exposes tap inc/dec, load and readback controls. It also generates the OSERDES reset. It sits between the PHY clocking and the lane's OSERDES, driven by calibration logic.

## Interface
- CLKOUT_DIV, 4: divide ratio, legal 2..16; any other value is an elaboration error.
- COARSE_DELAY, 0: coarse tap value after reset, 0..63.
- FINE_DELAY, 0: fine tap value after reset, 0..63.
- OCLK_DELAY, 0: OCLK tap value after reset, 0..63.
- COARSE_BYPASS, 1'b0: 1 forces the effective coarse delay to 0 and ignores coarse steps.
- EN_OSERDES_RST, 1'b0: enables OSERDESRST generation.
- OCLKDELAY_INV, 1'b0: inverts OCLKDELAYED.
- SYNC_IN_DIV_RST, 1'b0: SYNCIN also acts as a divider reset.

Ports:
- FREQREFCLK  in  1  the single clock; all logic is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- COARSEENABLE / COARSEINC  in  1/1  coarse tap step enable / direction (1 = increment).
- FINEENABLE / FINEINC  in  1/1  fine tap step enable / direction.
- COUNTERLOADEN  in  1  loads the selected tap from COUNTERLOADVAL.
- COUNTERLOADVAL  in  9  load value; only [5:0] is used.
- COUNTERREADEN  in  1  captures the selected tap into COUNTERREADVAL.
- SELFINEOCLKDELAY  in  1  0 selects the fine tap; 1 selects the OCLK tap and adds it to the delay path.
- DIVIDERST  in  1  synchronous divider hold.
- EDGEADV  in  1  advances divider phase by one cycle.
- SYNCIN  in  1  divider reset when SYNC_IN_DIV_RST=1.
- OCLK  out  1  FREQREFCLK passed through combinationally.
- OCLKDIV  out  1  divided clock.
- OCLKDELAYED  out  1  delayed, optionally inverted, divided clock.
- OSERDESRST  out  1  OSERDES reset.
- COARSEOVERFLOW / FINEOVERFLOW  out  1/1  one-cycle wrap pulses.
- COUNTERREADVAL  out  9  readback value.

## Operation
- Constants: D = CLKOUT_DIV; POS = floor(D/2).
- divrst = DIVIDERST | (SYNC_IN_DIV_RST & SYNCIN).

Divider:
- div_cnt counts 0..D-1 and wraps.
- OCLKDIV <= (div_cnt < POS), so the period is D cycles with POS cycles high.
- EDGEADV=1 steps div_cnt by 2 modulo D instead of 1.
- divrst=1 forces div_cnt=0 and OCLKDIV=0. divrst takes priority over EDGEADV.

Coarse tap (6 bit):
- When COARSEENABLE=1 and COARSE_BYPASS=0, it steps ±1 with wrap: 63→0 on increment, 0→63 on decrement.
- A wrapping step makes COARSEOVERFLOW=1 for exactly the following cycle.

Fine tap:
- Identical stepping and wrap behaviour, using FINEENABLE/FINEINC and FINEOVERFLOW.
- The fine tap has no cycle-level effect on clock outputs.

Load:
- COUNTERLOADEN=1 writes COUNTERLOADVAL[5:0] to the fine tap (SELFINEOCLKDELAY=0) or the OCLK tap (SELFINEOCLKDELAY=1).
- A load beats a same-cycle FINEENABLE step on the same tap and produces no overflow pulse.

Read:
- COUNTERREADEN=1 registers {3'b000, selected tap}, using the tap value before any same-cycle update.
- COUNTERREADVAL otherwise holds its value.

Delay path:
- hist is a 127-bit shift register of OCLKDIV, with hist[0] = current OCLKDIV.
- dly = (COARSE_BYPASS ? 0 : coarse) + (SELFINEOCLKDELAY ? oclk_tap : 0), range 0..126.
- OCLKDELAYED = hist[dly] ^ OCLKDELAY_INV.

OSERDESRST:
- With EN_OSERDES_RST=0, it is constant 0.
- With EN_OSERDES_RST=1, it is 1 out of reset and whenever divrst=1. It clears on the cycle after OCLKDIV is first sampled 1 following the reset or divrst release.

## Timing
Reset values:
- div_cnt=0, OCLKDIV=0, hist=0 (so OCLKDELAYED=OCLKDELAY_INV).
- Taps = COARSE_DELAY / FINE_DELAY / OCLK_DELAY.
- Overflow flags 0, COUNTERREADVAL=0, OSERDESRST=EN_OSERDES_RST.

Latencies:
- All outputs except OCLK are registered.
- OCLKDIV first goes high on the first edge after reset deassertion.
- Tap steps, loads and reads take effect one cycle after the control is sampled.
- OCLKDELAYED reflects a new dly on the next edge.

Boundary conditions:
- Reset deassertion is synchronous-release safe: state changes only on clock edges after RST_N rises.
- Reset asserted mid-operation clears immediately to the reset values.
- Controls held for N cycles produce N steps.

## Structure
- Shared package: tap width (6), read width (9), history depth (127), divide-ratio bounds (2..16).
- One natural sub-module, phaser_tap_counter: a 6-bit wrap up/down counter with load and overflow pulse. Instantiate it 3× for coarse, fine and OCLK; the OCLK instance has no step inputs.
- Divider, history, OSERDESRST and readback stay in the top level.

## Test plan
1. D=4, no controls: after reset OCLKDIV is the pattern 1,1,0,0 repeating from the first edge. OSERDESRST=0. OCLKDELAYED equals OCLKDIV.
2. D=5, COARSE_DELAY=3: OCLKDELAYED equals OCLKDIV delayed 3 cycles. Then 2 COARSEINC steps → delay 5 (OCLKDELAYED equals OCLKDIV delayed 5 cycles).
3. COARSE_DELAY=63, one increment: tap becomes 0 and COARSEOVERFLOW pulses for 1 cycle. A decrement from 0 gives 63 and another pulse.
4. SELFINEOCLKDELAY=1, load 9'h00A then read: COUNTERREADVAL=9'h00A and the delay grows by 10 cycles. Load plus FINEENABLE in the same cycle with SELFINEOCLKDELAY=0: load wins.
5. EN_OSERDES_RST=1, DIVIDERST held 5 cycles: OCLKDIV=0 and OSERDESRST=1 throughout. After release, OSERDESRST clears one cycle after OCLKDIV first goes high.
6. EDGEADV pulse at D=4: the OCLKDIV phase shifts one cycle earlier. EDGEADV together with DIVIDERST: divider reset wins.
